busca_instrucao: RTL

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

---
 rtl/busca_mem_if.sv | 12 +
 rtl/busca_instrucao.sv | 115 +++++++++++
 2 files changed

// File: rtl/busca_mem_if.sv
// Instruction-memory read bus between the fetch stage (master) and the memory (slave).
interface busca_mem_if #(
  parameter int LARGURA = 32
);
  logic               mem_req;
  logic [LARGURA-1:0] mem_end;
  logic               mem_ack;
  logic [LARGURA-1:0] mem_dado;

  modport master (output mem_req, output mem_end, input mem_ack, input mem_dado);
  modport slave  (input mem_req, input mem_end, output mem_ack, output mem_dado);
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: issues one memory read per PC value, offers the word downstream,
// and holds the PC while a fetch is outstanding, after HLT, or after a memory timeout.
module busca_instrucao #(
  parameter int         LARGURA    = 32,
  parameter int         TIMEOUT    = 255,
  parameter logic [5:0] OPCODE_HLT = 6'b111111
) (
  input  logic               clock,
  input  logic               reseta,
  input  logic [LARGURA-1:0] endereco,
  input  logic               descarta,
  input  logic               consumidor_pronto,
  busca_mem_if.master        mem,
  output logic [LARGURA-1:0] instrucao,
  output logic               valida,
  output logic               halt,
  output logic               erro
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {OCIOSO, ESPERA, ENTREGA, PARADO, ERRO} estado_t;

  estado_t            estado_q;
  logic [CW-1:0]      cont_q;
  logic [CW-1:0]      cont_d;
  logic               descarte_q;
  logic               mem_req_q;
  logic [LARGURA-1:0] mem_end_q;
  logic [LARGURA-1:0] instrucao_q;
  logic               valida_q;
  logic               erro_q;
  logic               eh_hlt;

  // NOTE: every signal below is assigned on every pass, so no latch can be inferred.
  always_comb begin
    cont_d = cont_q + 1'b1;
    eh_hlt = (instrucao_q[LARGURA-1 -: 6] == OPCODE_HLT);
    halt   = !((estado_q == ENTREGA) && consumidor_pronto && !descarta && !eh_hlt);
  end

  // NOTE: state and registered outputs use <= so every branch sees the pre-edge values.
  always_ff @(posedge clock) begin
    if (!reseta) begin
      estado_q    <= OCIOSO;
      cont_q      <= '0;
      descarte_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_end_q   <= '0;
      instrucao_q <= '0;
      valida_q    <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          // A jump this cycle means endereco is stale; wait for the new PC.
          if (!descarta) begin
            mem_end_q  <= endereco;
            mem_req_q  <= 1'b1;
            cont_q     <= '0;
            descarte_q <= 1'b0;
            estado_q   <= ESPERA;
          end
        end
        ESPERA: begin
          if (descarta) descarte_q <= 1'b1;
          if (mem.mem_ack) begin
            mem_req_q <= 1'b0;
            if (!descarte_q) begin
              instrucao_q <= mem.mem_dado;
              valida_q    <= 1'b1;
              estado_q    <= ENTREGA;
            end else begin
              estado_q <= OCIOSO;
            end
          end else begin
            cont_q <= cont_d;
            if (cont_d == CW'(TIMEOUT)) begin
              mem_req_q <= 1'b0;
              erro_q    <= 1'b1;
              estado_q  <= ERRO;
            end
          end
        end
        ENTREGA: begin
          if (descarta) begin
            valida_q <= 1'b0;
            estado_q <= OCIOSO;
          end else if (consumidor_pronto) begin
            valida_q <= 1'b0;
            estado_q <= eh_hlt ? PARADO : OCIOSO;
          end
        end
        PARADO: begin
          if (descarta) estado_q <= OCIOSO;
        end
        ERRO: begin
          erro_q <= 1'b1;
        end
        default: begin
          mem_req_q <= 1'b0;
          valida_q  <= 1'b0;
          estado_q  <= OCIOSO;
        end
      endcase
    end
  end

  assign mem.mem_req = mem_req_q;
  assign mem.mem_end = mem_end_q;
  assign instrucao   = instrucao_q;
  assign valida      = valida_q;
  assign erro        = erro_q;

endmodule
